// File: rtl/dilithium_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dilithium_pkg
// Purpose  : Shared constants, FSM state type and bit-reversal helper for the
//            coefficient-RAM datapath blocks.
// Contents : POLY_N, BITREV_BITS, state_t {IDLE, RUN, DRAIN}, rev8()
// Revision : 1.0 - initial release
// ============================================================================
package dilithium_pkg;

    localparam int POLY_N      = 256;
    localparam int BITREV_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Reverse the low BITREV_BITS bits (NTT bit-reversed index).
    function automatic logic [BITREV_BITS-1:0] rev8(input logic [BITREV_BITS-1:0] x);
        logic [BITREV_BITS-1:0] r;
        for (int i = 0; i < BITREV_BITS; i++) begin
            r[i] = x[BITREV_BITS-1-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid_fifo
// Purpose  : 2-entry FIFO holding words returned by the RAM until the stream
//            consumer accepts them.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            push, push_data - write one word
//            pop             - remove head word
//            pop_data        - head word (valid when occ != 0)
//            occ             - number of stored words, 0..2
// Revision : 1.0 - initial release
// ============================================================================
module stream_skid_fifo #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign pop_data = mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : ram_stream_reader
// Purpose  : Walks a programmed RAM address range through one read port of a
//            1-cycle-latency RAM and presents the words as a valid/ready
//            stream without drops or duplicates under backpressure.
// Ports    : clk, rst                    - clock, sync active-high reset
//            start, base_addr, num_words - transfer request (sampled in IDLE)
//            busy, done                  - transfer status
//            ram_en, ram_addr, ram_dout  - RAM read port
//            m_valid, m_data, m_ready    - output stream
//            bitrev                      - only with BITREV_RD_EN: bit-reversed
//                                          low-8-bit offset order
// Config   : `define BITREV_RD_EN adds the bitrev input and reversed order.
// Revision : 1.0 - initial release
// ============================================================================
module ram_stream_reader
    import dilithium_pkg::*;
#(
    parameter  int WIDTH  = 96,
    parameter  int LENGTH = 1024,
    localparam int ADDR_W = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   num_words,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_dout,
    output logic              m_valid,
    output logic [WIDTH-1:0]  m_data,
`ifdef BITREV_RD_EN
    input  logic              bitrev,
`endif
    input  logic              m_ready
);

    localparam logic [ADDR_W:0] LEN_W = (ADDR_W+1)'(LENGTH);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   num_q;
    logic [ADDR_W:0]   issued;
    logic [ADDR_W:0]   issued_nx;
    logic              inflight;
    logic [1:0]        occ;
    logic              pop;
    logic [2:0]        fill;
    logic [ADDR_W-1:0] lin_off;
    logic [ADDR_W-1:0] offset;
    logic [ADDR_W:0]   addr_sum;

    assign pop       = m_valid && m_ready;
    assign issued_nx = issued + 1'b1;
    assign lin_off   = issued[ADDR_W-1:0];

    // Words stored plus the one on its way back, after this cycle's pop;
    // issuing only below 2 guarantees the 2-entry FIFO never overflows.
    assign fill   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign ram_en = (state == RUN) && (issued < num_q) && (fill < 3'd2);

`ifdef BITREV_RD_EN
    logic              bitrev_q;
    logic [ADDR_W-1:0] rev_off;

    generate
        if (ADDR_W > BITREV_BITS) begin : g_rev_hi
            assign rev_off = {lin_off[ADDR_W-1:BITREV_BITS], rev8(lin_off[BITREV_BITS-1:0])};
        end else if (ADDR_W == BITREV_BITS) begin : g_rev_eq
            assign rev_off = rev8(lin_off);
        end else begin : g_rev_none
            assign rev_off = lin_off;
        end
    endgenerate

    assign offset = bitrev_q ? rev_off : lin_off;
`else
    assign offset = lin_off;
`endif

    // Both operands are below LENGTH, so one conditional subtract is the modulo.
    assign addr_sum = {1'b0, base_q} + {1'b0, offset};
    assign ram_addr = (addr_sum >= LEN_W) ? ADDR_W'(addr_sum - LEN_W) : addr_sum[ADDR_W-1:0];

    stream_skid_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_data (ram_dout),
        .pop       (pop),
        .pop_data  (m_data),
        .occ       (occ)
    );

    assign m_valid = (occ != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base_q   <= '0;
            num_q    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef BITREV_RD_EN
            bitrev_q <= 1'b0;
`endif
        end else begin
            inflight <= ram_en;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_words == '0) begin
                            done <= 1'b1;
                        end else begin
                            base_q <= base_addr;
                            num_q  <= num_words;
                            issued <= '0;
                            busy   <= 1'b1;
                            state  <= RUN;
`ifdef BITREV_RD_EN
                            bitrev_q <= bitrev;
`endif
                        end
                    end
                end
                RUN: begin
                    if (ram_en) begin
                        issued <= issued_nx;
                        if (issued_nx == num_q) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Finish in the cycle after the last word is accepted.
                    if (!inflight && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_stream_reader
// Purpose  : Self-checking bench for ram_stream_reader coupled to a 1-cycle
//            latency RAM model preloaded with mem[i] = i. Expected addresses
//            and data come from the address-range rules, held in queues.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_stream_reader;

    localparam int WIDTH  = 96;
    localparam int LENGTH = 1024;
    localparam int ADDR_W = $clog2(LENGTH);

    typedef logic [WIDTH-1:0] word_t;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   num_words;
    logic              busy;
    logic              done;
    logic              ram_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [WIDTH-1:0]  ram_dout;
    logic              m_valid;
    logic [WIDTH-1:0]  m_data;
    logic              m_ready;
`ifdef BITREV_RD_EN
    logic              bitrev;
`endif

    ram_stream_reader #(
        .WIDTH  (WIDTH),
        .LENGTH (LENGTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .ram_en    (ram_en),
        .ram_addr  (ram_addr),
        .ram_dout  (ram_dout),
        .m_valid   (m_valid),
        .m_data    (m_data),
`ifdef BITREV_RD_EN
        .bitrev    (bitrev),
`endif
        .m_ready   (m_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: registered read, mem[i] = i.
    logic [WIDTH-1:0] mem [LENGTH];
    initial begin
        ram_dout = '0;
        for (int i = 0; i < LENGTH; i++) mem[i] = word_t'(i);
    end
    always @(posedge clk) if (ram_en) ram_dout <= mem[ram_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input word_t got, input word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference order: offset k, or {k[hi], reversed k[7:0]} in bit-reversed mode.
    function automatic int exp_addr(input int base, input int k, input bit brev);
        int off;
        int r;
        off = k;
        if (brev) begin
            r = 0;
            for (int b = 0; b < 8; b++) if (((k >> b) & 1) != 0) r = r | (1 << (7 - b));
            off = (k / 256) * 256 + r;
        end
        return (base + off) % LENGTH;
    endfunction

    int    addr_q[$];
    word_t data_q[$];
    int    exp_num, en_cnt, acc_cnt, vld_cnt, done_cnt;
    int    first_vld, last_acc, done_cyc;
    bit    ready_rand = 1'b0;
    bit    prev_stall = 1'b0;
    word_t prev_data  = '0;

    // Consumer: m_ready changes just after each rising edge.
    initial m_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (ram_en) begin
                en_cnt++;
                if (addr_q.size() > 0) begin
                    int a;
                    a = addr_q.pop_front();
                    check("rd_addr", word_t'(ram_addr), word_t'(a));
                end else begin
                    check("rd_extra", word_t'(en_cnt), word_t'(exp_num));
                end
            end
            if (prev_stall) begin
                check("hold_valid", word_t'(m_valid), word_t'(1));
                check("hold_data", m_data, prev_data);
            end
            if (m_valid) begin
                vld_cnt++;
                if (first_vld < 0) first_vld = cyc;
            end
            if (m_valid && m_ready) begin
                acc_cnt++;
                last_acc = cyc;
                if (data_q.size() > 0) begin
                    word_t d;
                    d = data_q.pop_front();
                    check("data", m_data, d);
                end else begin
                    check("acc_extra", word_t'(acc_cnt), word_t'(exp_num));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_vs_valid", word_t'(m_valid), word_t'(0));
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    task automatic setup_xfer(input int base, input int num, input bit rnd, input bit brev);
        addr_q.delete();
        data_q.delete();
        for (int k = 0; k < num; k++) begin
            int a;
            a = exp_addr(base, k, brev);
            addr_q.push_back(a);
            data_q.push_back(word_t'(a));
        end
        exp_num    = num;
        en_cnt     = 0;
        acc_cnt    = 0;
        vld_cnt    = 0;
        done_cnt   = 0;
        first_vld  = -1;
        last_acc   = -1;
        done_cyc   = -1;
        ready_rand = rnd;
    endtask

    task automatic pulse_start(input int base, input int num, input bit brev, output int t0);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = ADDR_W'(base);
        num_words = (ADDR_W+1)'(num);
`ifdef BITREV_RD_EN
        bitrev    = brev;
`endif
        t0 = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_xfer(input int base, input int num, input bit rnd, input bit brev,
                            input bit glitch, input bit chk_timing);
        int t0;
        setup_xfer(base, num, rnd, brev);
        pulse_start(base, num, brev, t0);
        @(negedge clk);
        check("busy_start", word_t'(busy), word_t'(num > 0));
        for (int i = 0; i < 6000 && done_cnt == 0; i++) begin
            @(posedge clk);
            if (glitch && i == 8) begin
                #1;
                start     = 1'b1;
                base_addr = ADDR_W'(500);
                num_words = (ADDR_W+1)'(3);
            end else if (glitch && i == 9) begin
                #1;
                start = 1'b0;
            end
        end
        if (done_cnt == 0) check("timeout", word_t'(done_cnt), word_t'(1));
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("acc_cnt", word_t'(acc_cnt), word_t'(num));
        check("rd_cnt", word_t'(en_cnt), word_t'(num));
        check("done_cnt", word_t'(done_cnt), word_t'(1));
        check("busy_end", word_t'(busy), word_t'(0));
        if (num > 0) begin
            check("done_lat", word_t'(done_cyc), word_t'(last_acc + 1));
            if (chk_timing) begin
                check("first_lat", word_t'(first_vld - t0), word_t'(3));
                check("b2b", word_t'(last_acc - first_vld), word_t'(num - 1));
            end
        end else begin
            check("done_lat0", word_t'(done_cyc), word_t'(t0 + 1));
            check("vld_cnt0", word_t'(vld_cnt), word_t'(0));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, word_t'(busy), word_t'(0));
        check({tag, "_done"}, word_t'(done), word_t'(0));
        check({tag, "_ram_en"}, word_t'(ram_en), word_t'(0));
        check({tag, "_ram_addr"}, word_t'(ram_addr), word_t'(0));
        check({tag, "_m_valid"}, word_t'(m_valid), word_t'(0));
        check({tag, "_m_data"}, m_data, word_t'(0));
    endtask

    initial begin
        int t0;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
`ifdef BITREV_RD_EN
        bitrev    = 1'b0;
`endif
        setup_xfer(0, 0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Full linear polynomial, back-to-back, latency checked.
        run_xfer(0, 256, 1'b0, 1'b0, 1'b0, 1'b1);
        // Address wrap past LENGTH-1.
        run_xfer(1020, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        // Random backpressure, start pulsed mid-transfer must be ignored.
        run_xfer(int'($urandom_range(0, LENGTH - 1)), 16, 1'b1, 1'b0, 1'b1, 1'b0);
        // Empty transfer.
        run_xfer(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-transfer after 5 accepted words.
        setup_xfer(0, 64, 1'b0, 1'b0);
        pulse_start(0, 64, 1'b0, t0);
        for (int i = 0; i < 100 && acc_cnt < 5; i++) @(posedge clk);
        check("pre_rst_acc", word_t'(acc_cnt >= 5), word_t'(1));
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_cnt = 0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("midrst_no_done", word_t'(done_cnt), word_t'(0));
        run_xfer(0, 4, 1'b0, 1'b0, 1'b0, 1'b1);

        // Randomized ranges, including a full-depth wrap.
        for (int n = 0; n < 4; n++) begin
            run_xfer(int'($urandom_range(0, LENGTH - 1)), int'($urandom_range(1, 40)),
                     1'b1, 1'b0, 1'b0, 1'b0);
        end
        run_xfer(int'($urandom_range(0, LENGTH - 1)), LENGTH, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef BITREV_RD_EN
        run_xfer(0, 256, 1'b0, 1'b1, 1'b0, 1'b1);
        run_xfer(int'($urandom_range(0, LENGTH - 1)), 300, 1'b1, 1'b1, 1'b0, 1'b0);
        run_xfer(0, 8, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
